// File: rtl/approx_round_acc_if.sv
// Sample/result handshake bundle for approx_round_acc.
// master: sample source + result consumer side; slave: the accumulator.
interface approx_round_acc_if #(
    parameter int DATA_W = 16,
    parameter int LSB_W  = 5,
    parameter int CNT_W  = 8
);
    localparam int ACC_W = DATA_W - LSB_W + CNT_W;

    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ready;
    logic              busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/approx_round_acc.sv
// Streaming accumulator: drops LSB_W low bits of each sample with a
// round-nearest style carry, sums len samples, presents the total.
// Two-stage pipeline: rounded sample register (r1/v1), then accumulator.
module approx_round_acc #(
    parameter int DATA_W = 16,
    parameter int LSB_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    approx_round_acc_if.slave  bus
);
    localparam int ACC_W = DATA_W - LSB_W + CNT_W;
    localparam int U_W   = DATA_W - LSB_W;
    localparam int R_W   = U_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [R_W-1:0]   r1;
    logic             v1;

    logic [U_W-1:0]   u;
    logic             rc;
    logic [R_W-1:0]   r;
    logic             in_rdy;
    logic             accept;

    // Rounded sample: upper field plus carry from the dropped field.
    always_comb begin
        u  = bus.in_data[DATA_W-1:LSB_W];
        rc = bus.in_data[LSB_W-1] | (&bus.in_data[LSB_W-2:0]);
        r  = {1'b0, u} + R_W'(rc);
    end

    // Handshake and status outputs, all from registered state.
    always_comb begin
        in_rdy        = (state == ACCUM) && (cnt != len_q);
        accept        = in_rdy && bus.in_valid;
        bus.in_ready  = in_rdy;
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_sum   = (state == DONE) ? acc : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    // Leaving ACCUM as soon as cnt reaches len_q is safe: that same edge
    // folds any pending r1 into acc, so the pipeline is empty in DONE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (cnt == len_q) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Job length, sample counter, stage-1 register and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            r1    <= '0;
            v1    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.len;
                        cnt   <= '0;
                        acc   <= '0;
                        v1    <= 1'b0;
                    end
                end
                ACCUM: begin
                    v1 <= accept;
                    if (accept) begin
                        r1  <= r;
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (v1) begin
                        acc <= acc + ACC_W'(r1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_approx_round_acc.sv
// Directed bench for approx_round_acc with a job-level reference model
// and a per-cycle compare process.
module tb_approx_round_acc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    approx_round_acc_if #(.DATA_W(16), .LSB_W(5), .CNT_W(8)) bus();

    approx_round_acc #(.DATA_W(16), .LSB_W(5), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    bit chk_on = 1'b0;

    // Reference model: 0 idle, 1 collecting, 2 result ready.
    int m_state = 0;
    int m_len   = 0;
    int m_cnt   = 0;
    int m_sum   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd(input int d);
        int up;
        int rc;
        up = d / 32;
        rc = (((d / 16) % 2) == 1 || (d % 16) == 15) ? 1 : 0;
        return up + rc;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update: job rules at the level of accepted samples and states.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_len = 0; m_cnt = 0; m_sum = 0;
        end else begin
            case (m_state)
                0: if (bus.start) begin
                    m_len = int'(bus.len); m_cnt = 0; m_sum = 0;
                    m_state = (bus.len == 0) ? 2 : 1;
                end
                1: if (m_cnt == m_len) m_state = 2;
                   else if (bus.in_valid) begin
                       m_cnt++;
                       m_sum += rnd(int'(bus.in_data));
                   end
                default: if (bus.out_ready) m_state = 0;
            endcase
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_in_ready", 32'(bus.in_ready), 32'(m_state == 1 && m_cnt < m_len));
            chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_state == 2));
            chk("cyc_busy", 32'(bus.busy), 32'(m_state != 0));
            if (m_state == 2) chk("cyc_out_sum", 32'(bus.out_sum), 32'(m_sum));
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_start(input int l);
        bus.len   = 8'(l);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] d, input int gap);
        bit got;
        int b;
        got = 1'b0;
        b = 0;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!got && b < 100) begin
            @(negedge clk);
            got = (bus.in_ready === 1'b1);
            tick();
            b++;
        end
        if (!got) chk("feed_timeout", 32'(bus.in_ready), 32'd1);
        last_acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm, input int exp_sum, input int exp_edge);
        int b;
        b = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && b < 60) begin
            @(negedge clk);
            b++;
        end
        if (bus.out_valid !== 1'b1) begin
            chk({nm, "_timeout"}, 32'(bus.out_valid), 32'd1);
        end else begin
            if (exp_edge >= 0) chk({nm, "_lat"}, 32'(cyc), 32'(exp_edge));
            chk(nm, 32'(bus.out_sum), 32'(exp_sum));
        end
    endtask

    task automatic take(input int hold, input int exp_sum, input bit start_too);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_sum", 32'(bus.out_sum), 32'(exp_sum));
        end
        bus.out_ready = 1'b1;
        if (start_too) begin
            bus.start = 1'b1;
            bus.len   = 8'd5;
        end
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        @(negedge clk);
        chk("post_take_busy", 32'(bus.busy), 32'd0);
        chk("post_take_valid", 32'(bus.out_valid), 32'd0);
        tick();
    endtask

    logic [15:0] rv [5] = '{16'h0010, 16'h000F, 16'h0007, 16'h0030, 16'hFFFF};
    int          re [5] = '{1, 1, 0, 2, 'h800};
    logic [15:0] sv [4] = '{16'h0010, 16'h0020, 16'h0007, 16'h001F};

    initial begin
        int first_acc;
        int s_edge;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk_on = 1'b1;
        tick();

        // Rounding vectors, one sample per job
        for (int i = 0; i < 5; i++) begin
            do_start(1);
            feed(rv[i], 0);
            wait_out($sformatf("round_%0d", i), re[i], last_acc + 1);
            take(0, re[i], 1'b0);
        end

        // Back-to-back stream of four samples
        do_start(4);
        feed(sv[0], 0);
        first_acc = last_acc;
        for (int i = 1; i < 4; i++) feed(sv[i], 0);
        chk("stream_rate", 32'(last_acc - first_acc), 32'd3);
        wait_out("stream_sum", 3, last_acc + 1);
        take(0, 3, 1'b1);

        // Input gaps, full-length job of maximum samples, then output stall
        do_start(255);
        for (int i = 0; i < 255; i++) feed(16'hFFFF, int'($urandom_range(0, 2)));
        wait_out("bp_sum", 'h7F800, last_acc + 1);
        take(10, 'h7F800, 1'b0);

        // Zero-length job
        do_start(0);
        s_edge = cyc;
        wait_out("len0_sum", 0, s_edge);
        chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
        take(0, 0, 1'b0);

        // start pulsed mid-job must not restart or resize it
        do_start(3);
        feed(16'h0010, 0);
        bus.len = 8'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed(16'h0030, 0);
        feed(16'h0020, 0);
        wait_out("restart_ign_sum", 4, last_acc + 1);
        take(0, 4, 1'b0);

        // Reset mid-job, then a fresh job
        do_start(4);
        feed(16'h0010, 0);
        feed(16'h0020, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        do_start(1);
        feed(16'h0010, 0);
        wait_out("after_rst_sum", 1, last_acc + 1);
        take(0, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
